// File: rtl/sipo_frame_rx.sv
// Serial-in/parallel-out frame receiver: start bit, WIDTH data bits, optional even parity, stop bit.
// Presents each good word in parallel with one-cycle out_valid/parity_err strobes; bad stop raises frame_err.
module sipo_frame_rx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter logic        IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_parallel;
    logic             r_valid;
    logic             r_perr;
    logic             r_ferr;
    logic             r_busy;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_mismatch_nxt;
    logic [WIDTH-1:0] w_parallel_nxt;
    logic             w_valid_nxt;
    logic             w_perr_nxt;
    logic             w_ferr_nxt;
    logic             w_busy_nxt;
    logic [WIDTH-1:0] w_shift;

    // Shift direction decides which end of the word the first data bit lands in.
    assign w_shift = (MSB_FIRST != 0) ? {r_shreg[WIDTH-2:0], serial_in}
                                      : {serial_in, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_shreg    <= '0;
            r_mismatch <= 1'b0;
            r_parallel <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shreg    <= w_shreg_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_parallel <= w_parallel_nxt;
            r_valid    <= w_valid_nxt;
            r_perr     <= w_perr_nxt;
            r_ferr     <= w_ferr_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next-state and output logic; strobes default low so they self-clear even when bit_en=0.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_shreg_nxt    = r_shreg;
        w_mismatch_nxt = r_mismatch;
        w_parallel_nxt = r_parallel;
        w_valid_nxt    = 1'b0;
        w_perr_nxt     = 1'b0;
        w_ferr_nxt     = 1'b0;

        if (bit_en) begin
            case (r_state)
                S_IDLE: begin
                    if (serial_in != IDLE_LEVEL) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    w_shreg_nxt = w_shift;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    w_mismatch_nxt = (^r_shreg) ^ serial_in;
                    w_state_nxt    = S_STOP;
                end
                S_STOP: begin
                    if (serial_in == IDLE_LEVEL) begin
                        w_parallel_nxt = r_shreg;
                        w_valid_nxt    = 1'b1;
                        w_perr_nxt     = (PARITY_EN != 0) && r_mismatch;
                        w_state_nxt    = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    // A held break must return to idle before a new start is honoured.
                    if (serial_in == IDLE_LEVEL) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign parallel_out = r_parallel;
    assign out_valid    = r_valid;
    assign parity_err   = r_perr;
    assign frame_err    = r_ferr;
    assign busy         = r_busy;

endmodule
